// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic definitions: default coefficient width and modulus.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ntt_pkg;

  localparam int unsigned NTT_W = 16;
  localparam int unsigned NTT_Q = 12289;

  typedef logic [NTT_W-1:0] coeff_t;

endpackage

// File: rtl/mod_adder_pipe_if.sv
// Operand/result handshake bundle for mod_adder_pipe.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//   slave  : the adder's view (consumes operands, produces results)
//   master : the producer/consumer view (drives operands, accepts results)
interface mod_adder_pipe_if #(
  parameter int W = ntt_pkg::NTT_W
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, y
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, y
  );

endinterface

// File: rtl/mod_reduce.sv
// Conditional subtract: folds a W+1-bit value in [0, 2Q-1] back into [0, Q-1].
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//   raw : W+1-bit unreduced value
//   y   : W-bit reduced value
module mod_reduce #(
  parameter int          W = ntt_pkg::NTT_W,
  parameter int unsigned Q = ntt_pkg::NTT_Q
) (
  input  logic [W:0]   raw,
  output logic [W-1:0] y
);

  localparam logic [W:0] QX = (W+1)'(Q);

  // For raw < 2Q the result of either branch fits in W bits, so the
  // truncating cast only drops a bit that is known to be zero.
  assign y = W'((raw >= QX) ? (raw - QX) : raw);

endmodule

// File: rtl/mod_adder_pipe.sv
// Two-stage pipelined modular adder/subtractor: y = (a +/- b) mod Q.
// Latency: 2 cycles input transfer to out_valid, 1 result/cycle sustained.
// Backpressure: stalls from the output stage backwards; in_ready depends only on stage state and out_ready.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of mod_adder_pipe_if (operands a/b/sub in, result y out)
// Build option: define MOD_ADDER_PIPE_SUB_EN to enable subtraction via bus.sub;
// without it the block is add-only and bus.sub is ignored.
module mod_adder_pipe
  import ntt_pkg::*;
#(
  parameter int          W = NTT_W,
  parameter int unsigned Q = NTT_Q
) (
  input  logic            clk,
  input  logic            rst,
  mod_adder_pipe_if.slave bus
);

  localparam logic [W:0] QX = (W+1)'(Q);

  logic         v1;
  logic [W:0]   raw_q;
  logic         v2;
  logic [W-1:0] y_q;

  logic         en1;
  logic         en2;
  logic [W:0]   raw_d;
  logic [W-1:0] red_d;

  // A stage may load when it is empty or its contents are leaving this cycle.
  assign en2 = !v2 || bus.out_ready;
  assign en1 = !v1 || en2;

  assign bus.in_ready  = en1;
  assign bus.out_valid = v2;
  assign bus.y         = y_q;

  // Stage 1 operand: one extra bit so the carry out of a+b is kept.
`ifdef MOD_ADDER_PIPE_SUB_EN
  // Subtraction is done as a + (Q - b), which stays non-negative and lands
  // in [1, 2Q-1], so the same single conditional subtract reduces it.
  always_comb begin
    raw_d = {1'b0, bus.a} + {1'b0, bus.b};
    if (bus.sub) begin
      raw_d = {1'b0, bus.a} + (QX - {1'b0, bus.b});
    end
  end
`else
  logic unused_sub;
  logic [W:0] unused_qx;
  assign unused_sub = bus.sub;
  assign unused_qx  = QX;
  assign raw_d      = {1'b0, bus.a} + {1'b0, bus.b};
`endif

  mod_reduce #(
    .W (W),
    .Q (Q)
  ) u_reduce (
    .raw (raw_q),
    .y   (red_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      raw_q <= '0;
      v2    <= 1'b0;
      y_q   <= '0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          raw_q <= raw_d;
        end
      end
      // y only moves when a real result enters stage 2, so it is held
      // stable whenever the output is stalled.
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          y_q <= red_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_adder_pipe.sv
// Directed bench for mod_adder_pipe: reset, latency, wrap boundaries,
// backpressure ordering, mid-stream reset and a full W=4/Q=13 sweep.
// Latency/backpressure are checked against an occupancy model kept in the bench.
module tb_mod_adder_pipe;
  import ntt_pkg::*;

`ifdef MOD_ADDER_PIPE_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_adder_pipe_if #(.W(16)) b16 ();
  mod_adder_pipe_if #(.W(4))  b4 ();

  mod_adder_pipe #(.W(16), .Q(12289)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  mod_adder_pipe #(.W(4),  .Q(13))    dut4  (.clk(clk), .rst(rst), .bus(b4));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int a;
    int b;
    bit s;
    int e;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic add_vec(input int a, input int b, input bit s, input int e);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.e = e;
    vq.push_back(v);
  endtask

  // Streams vq through the 16-bit instance. toggle=1 alternates out_ready 1/0.
  task automatic run_stream(input bit toggle, input string tag);
    int idx, outs, cyc, cnt, n;
    int expq[$];
    bit fi, fo, hold;
    logic [15:0] yprev;
    idx = 0; outs = 0; cyc = 0; cnt = 0; hold = 0; yprev = '0;
    n = vq.size();
    while (outs < n && cyc < 400) begin
      b16.in_valid = (idx < n);
      b16.a        = (idx < n) ? 16'(vq[idx].a) : 16'd0;
      b16.b        = (idx < n) ? 16'(vq[idx].b) : 16'd0;
      b16.sub      = (idx < n) ? vq[idx].s : 1'b0;
      b16.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      check({tag, "_in_ready"}, b16.in_ready, !(cnt == 2 && !b16.out_ready));
      if (hold) begin
        check({tag, "_hold_valid"}, b16.out_valid, 1);
        check({tag, "_hold_y"}, b16.y, yprev);
      end
      fi    = b16.in_valid && b16.in_ready;
      fo    = b16.out_valid && b16.out_ready;
      hold  = b16.out_valid && !b16.out_ready;
      yprev = b16.y;
      if (fo) begin
        if (expq.size() == 0) begin
          check({tag, "_spurious"}, fo, 0);
        end else begin
          check({tag, "_y"}, b16.y, expq.pop_front());
          outs++;
          cnt--;
        end
      end
      if (fi) begin
        expq.push_back(vq[idx].e);
        idx++;
        cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    b16.in_valid = 1'b0;
    check({tag, "_count"}, outs, n);
    if (!toggle) check({tag, "_cycles"}, cyc, n + 2);
    vq.delete();
  endtask

  initial begin
    int idx, outs, cyc, a, b, s, total;
    int sq[$];

    rst = 1'b1;
    b16.in_valid = 0; b16.a = 0; b16.b = 0; b16.sub = 0; b16.out_ready = 1;
    b4.in_valid = 0;  b4.a = 0;  b4.b = 0;  b4.sub = 0;  b4.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", b16.out_valid, 0);
    check("rst_y", b16.y, 0);
    check("rst_out_valid4", b4.out_valid, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", b16.in_ready, 1);

    // Latency: 5000+6000 = 11000 appears after the second edge.
    b16.a = 16'd5000; b16.b = 16'd6000; b16.sub = 0; b16.in_valid = 1;
    #1;
    check("lat_in_ready", b16.in_ready, 1);
    @(posedge clk); #1;
    b16.in_valid = 0;
    check("lat_stage1_valid", b16.out_valid, 0);
    @(posedge clk); #1;
    check("lat_out_valid", b16.out_valid, 1);
    check("lat_y", b16.y, 11000);
    @(posedge clk); #1;
    check("lat_drained", b16.out_valid, 0);

    // Boundaries at full rate.
    add_vec(12288, 1, 0, 0);
    add_vec(12288, 12288, 0, 12287);
    add_vec(6144, 6145, 0, 0);
    add_vec(0, 0, 0, 0);
    add_vec(12288, 0, 0, 12288);
    add_vec(3, 5, 1, SUB_ON ? 12287 : 8);
    add_vec(777, 777, 1, SUB_ON ? 0 : 1554);
    add_vec(4321, 0, 1, 4321);
    add_vec(100, 12200, 1, SUB_ON ? 189 : 11);
    run_stream(1'b0, "full");

    // Backpressure: 10 pairs, out_ready toggling.
    add_vec(7, 11000, 0, 11007);
    add_vec(1007, 11000, 0, 12007);
    add_vec(2007, 11000, 0, 718);
    add_vec(3007, 11000, 0, 1718);
    add_vec(4007, 11000, 0, 2718);
    add_vec(5007, 11000, 0, 3718);
    add_vec(6007, 11000, 0, 4718);
    add_vec(7007, 11000, 0, 5718);
    add_vec(8007, 11000, 0, 6718);
    add_vec(9007, 11000, 0, 7718);
    run_stream(1'b1, "bp");

    // Mid-stream reset with both stages full and a transfer offered.
    b16.out_ready = 0; b16.in_valid = 1; b16.a = 16'd1; b16.b = 16'd2; b16.sub = 0;
    @(posedge clk); #1;
    b16.a = 16'd3; b16.b = 16'd4;
    @(posedge clk); #1;
    check("mr_out_valid", b16.out_valid, 1);
    check("mr_y", b16.y, 3);
    check("mr_in_ready_full", b16.in_ready, 0);
    rst = 1'b1; b16.out_ready = 1; b16.a = 16'd9; b16.b = 16'd9;
    @(posedge clk); #1;
    rst = 1'b0; b16.in_valid = 0;
    check("mr_rst_out_valid", b16.out_valid, 0);
    check("mr_rst_y", b16.y, 0);
    #1;
    check("mr_in_ready", b16.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mr_no_stale", b16.out_valid, 0);
    end

    // Exhaustive W=4, Q=13 sweep against a reference model.
    total = 13 * 13 * 2;
    idx = 0; outs = 0; cyc = 0;
    while (outs < total && cyc < 1000) begin
      s = idx % 2;
      a = (idx / 2) / 13;
      b = (idx / 2) % 13;
      b4.in_valid = (idx < total);
      b4.a   = 4'(a);
      b4.b   = 4'(b);
      b4.sub = s[0];
      #1;
      if (b4.out_valid && b4.out_ready) begin
        if (sq.size() == 0) begin
          check("sweep_spurious", b4.out_valid, 0);
        end else begin
          check("sweep_y", b4.y, sq.pop_front());
          outs++;
        end
      end
      if (b4.in_valid && b4.in_ready) begin
        if (s == 1 && SUB_ON) sq.push_back((a - b + 13) % 13);
        else                  sq.push_back((a + b) % 13);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    b4.in_valid = 0;
    check("sweep_count", outs, total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_adder_pipe.md
MOD_ADDER_PIPE -- requirements
Module: mod_adder_pipe

Interface
REQ-001 SHALL have parameter W, default 16, operand/result width in bits.
REQ-002 SHALL have parameter Q, default 12289, modulus; 2 <= Q < 2^W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  first operand, legal range [0, Q-1].
REQ-008 SHALL have port b  input  W  second operand, legal range [0, Q-1].
REQ-009 SHALL have port sub  input  1  0 = (a+b) mod Q, 1 = (a-b) mod Q; sampled with a/b.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port y  output  W  result, always in [0, Q-1] for legal operands.

Function
REQ-013 SHALL transfer input when in_valid && in_ready on a rising clk edge; output when out_valid && out_ready.
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers raw W+1-bit sum a+b (or a+(Q-b) when sub=1); stage 2 registers reduced value (raw >= Q ? raw-Q : raw).
REQ-015 SHALL give latency 2 cycles from input transfer to out_valid when out_ready is held high; throughput 1 result/cycle.
REQ-016 SHALL compute sums in W+1 bits; carry out of bit W-1 SHALL never be lost.
REQ-017 SHALL use stage enables en2 = !v2 || out_ready, en1 = !v1 || en2; in_ready = en1 (combinational, no dependence on in_valid).
REQ-018 SHALL hold y and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL accept a new input in the same cycle an output transfers when pipeline full (full-rate under out_ready=1).
REQ-020 SHALL produce results in input order; no drop, no duplication.
REQ-021 Boundary: a+b = Q -> 0; a+b = 2Q-2 -> Q-2; sub with a=b -> 0; sub with b=0 -> a.
REQ-022 Results for operands >= Q are unspecified but SHALL not hang the handshake.

Reset
REQ-023 On rst=1 at a clk edge: stage valids, out_valid SHALL be 0; y SHALL be 0; in-flight data discarded.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-025 rst asserted mid-operation SHALL override any concurrent transfer in that cycle.

Configuration
REQ-026 Macro MOD_ADDER_PIPE_SUB_EN: defined -> sub port functional per REQ-009/014.
REQ-027 Not defined -> sub port present but ignored, block is add-only, Q-b path not synthesised; latency and handshake unchanged.

Structure
REQ-028 Shared package ntt_pkg SHALL hold default W, default Q, and a typedef for a W-bit coefficient.
REQ-029 Stage 2 conditional subtract SHALL be sub-module mod_reduce (input W+1 bits, output W bits, purely combinational).

Verification
REQ-030 Add, Q=12289: a=5000,b=6000, out_ready=1 -> y=11000 two cycles after transfer.
REQ-031 Wrap: a=12288,b=1 -> y=0; a=12288,b=12288 -> y=12287.
REQ-032 Sub (macro defined): a=3,b=5,sub=1 -> y=12287; macro undefined, same stimulus -> y=8.
REQ-033 Backpressure: stream 10 pairs with out_ready toggling 1/0 each cycle -> 10 correct results in order, in_ready low only when both stages full and out_ready=0.
REQ-034 Reset mid-stream: 2 items in flight, assert rst one cycle -> out_valid=0, y=0 next cycle; no stale result emerges afterwards.
REQ-035 Exhaustive sweep W=4, Q=13, all a,b in [0,12], both sub values -> every y matches reference model.
